// File: rtl/axi4lite_rw_scheduler.sv
// AXI4-Lite slave that funnels reads and writes onto one simple register bus.
// One transaction in flight; read/write contention is resolved round-robin.
module axi4lite_rw_scheduler #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
    output logic                              wr,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
    output logic                              rd,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     rdData
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_EXEC = 3'd1,
        WR_RESP = 3'd2,
        RD_EXEC = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last_wr;
    logic [AW-1:0]   r_awaddr;
    logic [DW-1:0]   r_wdata;
    logic            r_strb_ok;
    logic [AW-1:0]   r_araddr;
    logic [DW-1:0]   r_rdbuf;
    logic            w_grant_wr;
    logic            w_grant_rd;
    logic            w_wr_pend;

    assign S_AXI_RRESP = 2'b00;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= IDLE;
            r_last_wr <= 1'b1;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_strb_ok <= 1'b0;
            r_araddr  <= '0;
            r_rdbuf   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_wr) begin
                r_awaddr  <= S_AXI_AWADDR;
                r_wdata   <= S_AXI_WDATA;
                r_strb_ok <= &S_AXI_WSTRB;
                r_last_wr <= 1'b1;
            end
            if (w_grant_rd) begin
                r_araddr  <= S_AXI_ARADDR;
                r_last_wr <= 1'b0;
            end
            if (r_state == RD_EXEC)
                r_rdbuf <= rdData;
        end
    end

    always_comb begin
        w_next        = IDLE;
        w_wr_pend     = S_AXI_AWVALID & S_AXI_WVALID;
        w_grant_wr    = 1'b0;
        w_grant_rd    = 1'b0;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = 2'b00;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RDATA   = '0;
        wr            = 1'b0;
        wrAddr        = '0;
        wrData        = '0;
        rd            = 1'b0;
        rdAddr        = '0;
        unique case (r_state)
            IDLE: begin
                // Gated by reset so every output reads 0 while reset is held
                w_grant_wr = S_AXI_ARESETN & w_wr_pend
                           & (~S_AXI_ARVALID | ~r_last_wr);
                w_grant_rd = S_AXI_ARESETN & S_AXI_ARVALID
                           & (~w_wr_pend | r_last_wr);
                S_AXI_AWREADY = w_grant_wr;
                S_AXI_WREADY  = w_grant_wr;
                S_AXI_ARREADY = w_grant_rd;
                if (w_grant_wr)
                    w_next = WR_EXEC;
                else if (w_grant_rd)
                    w_next = RD_EXEC;
            end
            WR_EXEC: begin
                if (r_strb_ok) begin
                    wr     = 1'b1;
                    wrAddr = r_awaddr;
                    wrData = r_wdata;
                end
                w_next = WR_RESP;
            end
            WR_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = r_strb_ok ? 2'b00 : 2'b10;
                w_next = S_AXI_BREADY ? IDLE : WR_RESP;
            end
            RD_EXEC: begin
                rd     = 1'b1;
                rdAddr = r_araddr;
                w_next = RD_RESP;
            end
            RD_RESP: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RDATA  = r_rdbuf;
                w_next = S_AXI_RREADY ? IDLE : RD_RESP;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
